// File: rtl/wb_stage_if.sv
// MEM->WB bundle: MEM-stage results in, regfile write port out.
interface wb_stage_if;
  logic        stall_mem;
  logic        stall_wb;
  logic        flush;
  logic        mem_wreg;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ld_type;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_ld_data;
  logic [31:0] mem_rt_data;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  modport master (
    output stall_mem, stall_wb, flush,
    output mem_wreg, mem_wd, mem_wdata,
    output mem_ld_type, mem_addr_lo,
    output mem_ld_data, mem_rt_data,
    input  wb_we, wb_waddr, wb_wdata
  );

  modport slave (
    input  stall_mem, stall_wb, flush,
    input  mem_wreg, mem_wd, mem_wdata,
    input  mem_ld_type, mem_addr_lo,
    input  mem_ld_data, mem_rt_data,
    output wb_we, wb_waddr, wb_wdata
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB register with big-endian load formatter.
// UNALIGNED_LOAD_EN enables LWL/LWR merging.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;
  localparam logic [2:0] LD_LWL  = 3'd6;
  localparam logic [2:0] LD_LWR  = 3'd7;

  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] fmt;
  logic              bad;
  logic [DATA_W-1:0] ld;
  logic [DATA_W-1:0] rt;
  logic [1:0]        lo;

  assign ld = bus.mem_ld_data;
  assign rt = bus.mem_rt_data;
  assign lo = bus.mem_addr_lo;

`ifndef UNALIGNED_LOAD_EN
  logic unused_rt;
  assign unused_rt = ^rt;
`endif

  always_comb begin
    lane_b = ld[31:24];
    unique case (lo)
      2'd0: lane_b = ld[31:24];
      2'd1: lane_b = ld[23:16];
      2'd2: lane_b = ld[15:8];
      2'd3: lane_b = ld[7:0];
    endcase
  end

  assign lane_h = lo[1] ? ld[15:0] : ld[31:16];

  // bad: misaligned or unsupported load; suppresses write and zeroes data
  always_comb begin
    fmt = '0;
    bad = 1'b0;
    unique case (bus.mem_ld_type)
      LD_NONE: fmt = bus.mem_wdata;
      LD_LB:   fmt = {{24{lane_b[7]}}, lane_b};
      LD_LBU:  fmt = {24'h0, lane_b};
      LD_LH: begin
        bad = lo[0];
        fmt = {{16{lane_h[15]}}, lane_h};
      end
      LD_LHU: begin
        bad = lo[0];
        fmt = {16'h0, lane_h};
      end
      LD_LW: begin
        bad = |lo;
        fmt = ld;
      end
`ifdef UNALIGNED_LOAD_EN
      LD_LWL: begin
        unique case (lo)
          2'd0: fmt = ld;
          2'd1: fmt = {ld[23:0], rt[7:0]};
          2'd2: fmt = {ld[15:0], rt[15:0]};
          2'd3: fmt = {ld[7:0], rt[23:0]};
        endcase
      end
      LD_LWR: begin
        unique case (lo)
          2'd0: fmt = {rt[31:8], ld[31:24]};
          2'd1: fmt = {rt[31:16], ld[31:16]};
          2'd2: fmt = {rt[31:24], ld[31:8]};
          2'd3: fmt = ld;
        endcase
      end
`else
      LD_LWL:  bad = 1'b1;
      LD_LWR:  bad = 1'b1;
`endif
    endcase
  end

  // flush and a MEM-only stall both insert a bubble; stall_wb alone holds
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (bus.flush ||
                 (bus.stall_mem && !bus.stall_wb)) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (!bus.stall_wb) begin
      we_q    <= bus.mem_wreg && (|bus.mem_wd) && !bad;
      waddr_q <= bus.mem_wd;
      wdata_q <= bad ? '0 : fmt;
    end
  end

  assign bus.wb_we    = we_q;
  assign bus.wb_waddr = waddr_q;
  assign bus.wb_wdata = wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage against a spec-level model,
// plus literal directed checks.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst;
  int   ncmp = 0;
  int   nerr = 0;
  bit   armed = 1'b0;

  logic        e_we;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  always #5 clk = ~clk;

  wb_stage_if bus ();

  wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  // returns {ok, data}; ok=0 means misaligned/unsupported
  function automatic logic [32:0] model_fmt(
      input logic [2:0] t, input logic [1:0] lo,
      input logic [31:0] wd, input logic [31:0] ld,
      input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [63:0] m;
    b = 8'((ld >> (8 * (3 - int'(lo)))) & 32'hFF);
    h = 16'((ld >> (lo[1] ? 0 : 16)) & 32'hFFFF);
    case (t)
      3'd0: return {1'b1, wd};
      3'd1: return {1'b1, 32'($signed(b))};
      3'd2: return {1'b1, 32'(b)};
      3'd3: return lo[0] ? 33'd0 : {1'b1, 32'($signed(h))};
      3'd4: return lo[0] ? 33'd0 : {1'b1, 32'(h)};
      3'd5: return (lo != 0) ? 33'd0 : {1'b1, ld};
`ifdef UNALIGNED_LOAD_EN
      3'd6: begin
        m = (64'd1 << (8 * int'(lo))) - 1;
        return {1'b1, (ld << (8 * int'(lo))) | (rt & m[31:0])};
      end
      3'd7: begin
        m = (64'd1 << (8 * (int'(lo) + 1))) - 1;
        return {1'b1, (ld >> (8 * (3 - int'(lo))))
                      | (rt & ~m[31:0])};
      end
`endif
      default: return 33'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [32:0] f;
    if (rst) begin
      e_we = 0; e_waddr = 0; e_wdata = 0;
      armed = 1'b1;
    end else if (bus.flush ||
                 (bus.stall_mem && !bus.stall_wb)) begin
      e_we = 0; e_waddr = 0; e_wdata = 0;
    end else if (!bus.stall_wb) begin
      f = model_fmt(bus.mem_ld_type, bus.mem_addr_lo,
                    bus.mem_wdata, bus.mem_ld_data,
                    bus.mem_rt_data);
      e_we    = f[32] && bus.mem_wreg && (bus.mem_wd != 0);
      e_waddr = bus.mem_wd;
      e_wdata = f[32] ? f[31:0] : 32'd0;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_we", 32'(bus.wb_we), 32'(e_we));
      chk("m_waddr", 32'(bus.wb_waddr), 32'(e_waddr));
      chk("m_wdata", bus.wb_wdata, e_wdata);
    end
  end

  task automatic drv(input logic r, input logic sm,
                     input logic sw, input logic fl,
                     input logic wr, input logic [4:0] wd,
                     input logic [31:0] wdat,
                     input logic [2:0] t, input logic [1:0] lo,
                     input logic [31:0] ld,
                     input logic [31:0] rt);
    rst = r;
    bus.stall_mem = sm; bus.stall_wb = sw; bus.flush = fl;
    bus.mem_wreg = wr; bus.mem_wd = wd;
    bus.mem_wdata = wdat; bus.mem_ld_type = t;
    bus.mem_addr_lo = lo; bus.mem_ld_data = ld;
    bus.mem_rt_data = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string n, input logic we,
                     input logic [4:0] wa,
                     input logic [31:0] wdv);
    chk({n, "_we"}, 32'(bus.wb_we), 32'(we));
    chk({n, "_waddr"}, 32'(bus.wb_waddr), 32'(wa));
    chk({n, "_wdata"}, bus.wb_wdata, wdv);
  endtask

  initial begin
    drv(1, 0, 0, 0, 1, 5, 32'h55, 0, 0, 0, 0);
    out("rst1", 0, 0, 0);
    drv(1, 0, 0, 0, 1, 5, 32'h55, 0, 0, 0, 0);
    out("rst2", 0, 0, 0);
    drv(0, 0, 0, 0, 1, 5, 32'h55, 0, 0, 0, 0);
    out("rel", 1, 5, 32'h55);

    drv(0, 0, 0, 0, 1, 3, 0, 1, 1, 32'h12F35678, 0);
    out("lb", 1, 3, 32'hFFFF_FFF3);
    drv(0, 0, 0, 0, 1, 3, 0, 2, 1, 32'h12F35678, 0);
    out("lbu", 1, 3, 32'h0000_00F3);
    drv(0, 0, 0, 0, 1, 3, 0, 3, 2, 32'h12F35678, 0);
    out("lh", 1, 3, 32'h0000_5678);
    drv(0, 0, 0, 0, 1, 9, 0, 5, 2, 32'h12F35678, 0);
    out("lw_mis", 0, 9, 0);
    drv(0, 0, 0, 0, 1, 0, 32'h1, 0, 0, 0, 0);
    out("wd0", 0, 0, 32'h1);

    drv(0, 0, 0, 0, 1, 7, 32'hAAAA, 0, 0, 0, 0);
    out("pre", 1, 7, 32'hAAAA);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 0, 1, 5'(10 + i), 32'(i), 0, 0, 0, 0);
      out("hold", 1, 7, 32'hAAAA);
    end
    drv(0, 1, 0, 0, 1, 4, 32'h4, 0, 0, 0, 0);
    out("smbub", 0, 0, 0);

    drv(0, 0, 0, 0, 1, 6, 32'h66, 0, 0, 0, 0);
    drv(0, 0, 1, 1, 1, 6, 32'h66, 0, 0, 0, 0);
    out("flsw", 0, 0, 0);
    drv(0, 0, 0, 0, 1, 6, 32'h66, 0, 0, 0, 0);
    drv(1, 0, 0, 1, 1, 6, 32'h66, 0, 0, 0, 0);
    out("flrst", 0, 0, 0);

    drv(0, 0, 0, 0, 1, 8, 0, 6, 1,
        32'hAABBCCDD, 32'h11223344);
`ifdef UNALIGNED_LOAD_EN
    out("lwl", 1, 8, 32'hBBCCDD44);
`else
    out("lwl", 0, 8, 0);
`endif
    drv(0, 0, 0, 0, 1, 8, 0, 7, 1,
        32'hAABBCCDD, 32'h11223344);
`ifdef UNALIGNED_LOAD_EN
    out("lwr", 1, 8, 32'h1122AABB);
`else
    out("lwr", 0, 8, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      drv(($urandom_range(63) == 0),
          ($urandom_range(3) == 0),
          ($urandom_range(3) == 0),
          ($urandom_range(15) == 0),
          1'($urandom),
          ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
          $urandom, 3'($urandom), 2'($urandom),
          $urandom, $urandom);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
